// File: rtl/uart_xmit_arb_pkg.sv
// Purpose : shared constants for the UART transmit arbiter slice (state codes, levels, byte width).
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: WORD_W, HI/LO, 2-bit state encoding ARB/LAUNCH/ACK_WAIT/FRAME, byte_t.
package uart_xmit_arb_pkg;

    localparam int WORD_W = 8;

    localparam logic HI = 1'b1;
    localparam logic LO = 1'b0;

    localparam logic [1:0] ST_ARB      = 2'd0;
    localparam logic [1:0] ST_LAUNCH   = 2'd1;
    localparam logic [1:0] ST_ACK_WAIT = 2'd2;
    localparam logic [1:0] ST_FRAME    = 2'd3;

    typedef logic [WORD_W-1:0] byte_t;

endpackage

// File: rtl/uart_xmit_arb_if.sv
// Purpose : bundle of requester-side and transmitter-side signals around the UART transmit arbiter.
// Latency : n/a (wires only).
// Backpr. : requesters hold reqH/byte until grantH; transmitter paces frames via xmit_doneH.
// Modports: master = arbiter (drives grantH, doneH, busyH, timeoutH, xmitH, xmit_dataH);
//           slave  = requesters + transmitter (drive reqH, req_dataH, xmit_doneH).
interface uart_xmit_arb_if #(
    parameter int NUM_REQ = 4
);
    import uart_xmit_arb_pkg::*;

    logic [NUM_REQ-1:0]        reqH;
    logic [NUM_REQ*WORD_W-1:0] req_dataH;
    logic [NUM_REQ-1:0]        grantH;
    logic [NUM_REQ-1:0]        doneH;
    logic                      busyH;
    logic                      timeoutH;
    logic                      xmitH;
    byte_t                     xmit_dataH;
    logic                      xmit_doneH;

    modport master (
        input  reqH, req_dataH, xmit_doneH,
        output grantH, doneH, busyH, timeoutH, xmitH, xmit_dataH
    );

    modport slave (
        output reqH, req_dataH, xmit_doneH,
        input  grantH, doneH, busyH, timeoutH, xmitH, xmit_dataH
    );

endinterface

// File: rtl/uart_xmit_arb_rr_pick.sv
// Purpose : combinational round-robin selector: first set request at or above ptr, with wrap.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; win is all-zero when no request is set.
// Ports   : reqH[N] requests, ptr[3] search start (< N); win[N] one-hot winner, win_idx[3] its index.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] reqH,
    input  logic [2:0]   ptr,
    output logic [N-1:0] win,
    output logic [2:0]   win_idx
);
    import uart_xmit_arb_pkg::*;

    logic [3:0] cand;
    logic       found;

    always_comb begin
        cand    = '0;
        found   = LO;
        win_idx = '0;
        for (int k = 0; k < N; k++) begin
            // Candidate index ptr+k folded back into 0..N-1 without a divider.
            cand = {1'b0, ptr} + 4'(k);
            if (cand >= 4'(N)) begin
                cand = cand - 4'(N);
            end
            if (!found && (|((reqH >> cand) & N'(1)))) begin
                found   = HI;
                win_idx = cand[2:0];
            end
        end
    end

    assign win = found ? (N'(1) << win_idx) : '0;

endmodule

// File: rtl/uart_xmit_arb.sv
// Purpose : round-robin share of one UART transmitter among NUM_REQ byte requesters.
// Latency : request sampled in ARB at n -> xmitH/grantH at n+1; doneH in first FRAME cycle with xmit_doneH high.
// Backpr. : no arbitration while xmit_doneH is low; one frame in flight at a time.
// Ports   : sys_clk, sys_rst (sync, active-high); bus = uart_xmit_arb_if.master
//           (reqH/req_dataH in, grantH/doneH/busyH/timeoutH/xmitH/xmit_dataH out, xmit_doneH in).
// Option  : define UART_XMIT_ARB_TIMEOUT_EN to bound ACK_WAIT/FRAME to TIMEOUT_CYC cycles each,
//           with a sticky timeoutH; otherwise both states wait indefinitely and timeoutH is 0.
module uart_xmit_arb #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 511
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    uart_xmit_arb_if.master bus
);
    import uart_xmit_arb_pkg::*;

    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
            $error("uart_xmit_arb: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
        end
    endgenerate

    logic [1:0]         state;
    logic [2:0]         ptr;
    logic [2:0]         idx;
    byte_t              data_q;

    logic [NUM_REQ-1:0] win;
    logic [2:0]         win_idx;
    logic [2:0]         ptr_nxt;
    logic               arb_go;
    logic               wait_expired;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .reqH    (bus.reqH),
        .ptr     (ptr),
        .win     (win),
        .win_idx (win_idx)
    );

    // A busy transmitter blocks arbitration entirely so a stale idle level cannot start a second frame.
    assign arb_go  = bus.xmit_doneH && (|win);
    assign ptr_nxt = (win_idx == 3'(NUM_REQ - 1)) ? 3'd0 : (win_idx + 3'd1);

`ifdef UART_XMIT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;

    // Expires on the TIMEOUT_CYC-th cycle spent in the current wait state.
    assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wait_cnt  <= '0;
            timeout_q <= LO;
        end else begin
            if (state == ST_LAUNCH || (state == ST_ACK_WAIT && !bus.xmit_doneH)) begin
                wait_cnt <= '0;
            end else if ((state == ST_ACK_WAIT || state == ST_FRAME) && !wait_expired) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (wait_expired && ((state == ST_ACK_WAIT && bus.xmit_doneH) ||
                                 (state == ST_FRAME && !bus.xmit_doneH))) begin
                timeout_q <= HI;
            end
        end
    end

    assign bus.timeoutH = timeout_q;
`else
    assign wait_expired = LO;
    assign bus.timeoutH = LO;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state  <= ST_ARB;
            ptr    <= '0;
            idx    <= '0;
            data_q <= '0;
        end else begin
            case (state)
                ST_ARB: begin
                    if (arb_go) begin
                        idx    <= win_idx;
                        data_q <= WORD_W'(bus.req_dataH >> {win_idx, 3'b000});
                        ptr    <= ptr_nxt;
                        state  <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    state <= ST_ACK_WAIT;
                end
                ST_ACK_WAIT: begin
                    // Falling xmit_doneH is the transmitter's acknowledgement of the launch.
                    if (!bus.xmit_doneH) begin
                        state <= ST_FRAME;
                    end else if (wait_expired) begin
                        state <= ST_ARB;
                    end
                end
                ST_FRAME: begin
                    // Completion wins over an expiry landing in the same cycle.
                    if (bus.xmit_doneH || wait_expired) begin
                        state <= ST_ARB;
                    end
                end
                default: begin
                    state <= ST_ARB;
                end
            endcase
        end
    end

    assign bus.xmitH      = (state == ST_LAUNCH);
    assign bus.xmit_dataH = data_q;
    assign bus.grantH     = (state == ST_LAUNCH) ? (ONE << idx) : '0;
    assign bus.doneH      = (state == ST_FRAME && bus.xmit_doneH) ? (ONE << idx) : '0;
    assign bus.busyH      = (state != ST_ARB);

endmodule

// File: tb/tb_uart_xmit_arb.sv
// Purpose : self-checking bench for uart_xmit_arb with a transaction-level reference model.
// Latency : n/a.
// Backpr. : transmitter model drops xmit_doneH one cycle after xmitH for a random frame length.
module tb_uart_xmit_arb;
    import uart_xmit_arb_pkg::*;

    localparam int NR = 4;
    localparam int TO = 15;
`ifdef UART_XMIT_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic sys_clk = 1'b0;
    logic sys_rst;
    always #5 sys_clk = ~sys_clk;

    uart_xmit_arb_if #(.NUM_REQ(NR)) bus ();

    uart_xmit_arb #(.NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Stimulus state
    logic [NR-1:0] req_mask;
    logic [7:0]    bytes [NR];
    bit            rst_req, force_low, auto_refill, rand_req;
    int            tx_left, len_min, len_max;

    // Reference model: who owns the transmitter and what must appear next
    int         owner;
    bit         launch_due, accepted, to_flag;
    int         wcnt, m_ptr;
    logic [7:0] m_data;

    // Event log
    int            n_launch, n_done, open_launches;
    logic [NR-1:0] last_grant, last_done;
    logic [7:0]    last_data;
    int            grant_order[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int rr_expect(input logic [NR-1:0] r, input int p);
        for (int k = 0; k < NR; k++) begin
            if (r[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        owner = -1; launch_due = 0; accepted = 0; to_flag = 0;
        wcnt = 0; m_ptr = 0; m_data = 8'h00; open_launches = 0;
    endtask

    task automatic cycle();
        logic          xd;
        logic [NR-1:0] req_now, exp_grant, exp_done;
        logic [7:0]    bytes_now [NR];
        int            w;
        @(posedge sys_clk);
        #1;
        cyc++;
        xd = (!force_low && tx_left == 0);
        sys_rst = rst_req;
        bus.reqH = req_mask;
        bus.req_dataH = {bytes[3], bytes[2], bytes[1], bytes[0]};
        bus.xmit_doneH = xd;
        req_now = req_mask;
        for (int i = 0; i < NR; i++) bytes_now[i] = bytes[i];
        #1;
        exp_grant = launch_due ? NR'(1 << owner) : '0;
        exp_done  = (owner >= 0 && !launch_due && accepted && xd) ? NR'(1 << owner) : '0;
        check("xmitH", bus.xmitH, launch_due);
        check("grantH", bus.grantH, exp_grant);
        check("xmit_dataH", bus.xmit_dataH, m_data);
        check("doneH", bus.doneH, exp_done);
        check("busyH", bus.busyH, owner >= 0);
        check("timeoutH", bus.timeoutH, to_flag);

        if (bus.xmitH === 1'b1) begin
            n_launch++;
            last_grant = bus.grantH;
            last_data  = bus.xmit_dataH;
            open_launches++;
            check("one_launch_per_done", open_launches, 1);
            grant_order.push_back(onehot_idx(bus.grantH));
        end
        if (bus.doneH !== '0) begin
            n_done++;
            last_done = bus.doneH;
            open_launches = 0;
        end

        // Reference model advances on what was applied this cycle
        if (rst_req) begin
            model_reset();
        end else if (launch_due) begin
            launch_due = 0; accepted = 0; wcnt = 0;
        end else if (owner >= 0) begin
            if (!accepted && !xd) begin
                accepted = 1; wcnt = 0;
            end else if (accepted && xd) begin
                owner = -1;
            end else begin
                wcnt++;
                if (TO_EN && wcnt == TO) begin
                    to_flag = 1; owner = -1; open_launches = 0;
                end
            end
        end else if (xd && req_now != '0) begin
            w = rr_expect(req_now, m_ptr);
            owner = w; launch_due = 1;
            m_data = bytes_now[w];
            m_ptr = (w + 1) % NR;
        end

        // Requesters: drop after grant, optionally re-request
        for (int i = 0; i < NR; i++) begin
            if (bus.grantH[i] === 1'b1) req_mask[i] = 1'b0;
            if (auto_refill && bus.doneH[i] === 1'b1) begin
                req_mask[i] = 1'b1; bytes[i] = 8'($urandom);
            end
            if (rand_req && !req_mask[i] && bus.grantH[i] !== 1'b1 && $urandom_range(3) == 0) begin
                req_mask[i] = 1'b1; bytes[i] = 8'($urandom);
            end
        end

        // Transmitter: idle level drops the cycle after a launch and stays low for the frame
        if (tx_left > 0) tx_left--;
        if (bus.xmitH === 1'b1) tx_left = int'($urandom_range(len_max, len_min));
    endtask

    task automatic run_until_launch(input int budget, input string tag);
        int start = n_launch;
        for (int k = 0; k < budget && n_launch == start; k++) cycle();
        check({tag, "_launch_seen"}, n_launch != start, 1);
    endtask

    task automatic run_until_done(input int budget, input string tag);
        int start = n_done;
        for (int k = 0; k < budget && n_done == start; k++) cycle();
        check({tag, "_done_seen"}, n_done != start, 1);
    endtask

    task automatic drain(input string tag);
        bit ok = 0;
        for (int k = 0; k < 300 && !ok; k++) begin
            cycle();
            ok = (req_mask == '0 && owner < 0 && !launch_due);
        end
        check({tag, "_drained"}, ok, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_xmitH"}, bus.xmitH, 0);
        check({tag, "_grantH"}, bus.grantH, 0);
        check({tag, "_doneH"}, bus.doneH, 0);
        check({tag, "_busyH"}, bus.busyH, 0);
        check({tag, "_timeoutH"}, bus.timeoutH, 0);
        check({tag, "_xmit_dataH"}, bus.xmit_dataH, 0);
    endtask

    initial begin
        int start_n;
        req_mask = '0;
        for (int i = 0; i < NR; i++) bytes[i] = 8'h00;
        rst_req = 1; force_low = 0; auto_refill = 0; rand_req = 0;
        tx_left = 0; len_min = 4; len_max = 4;
        n_launch = 0; n_done = 0; last_grant = '0; last_done = '0; last_data = '0;
        model_reset();
        sys_rst = 1'b1;
        bus.reqH = '0; bus.req_dataH = '0; bus.xmit_doneH = 1'b1;

        // Reset state
        repeat (3) cycle();
        rst_req = 0;
        cycle();
        check_all_zero("reset");

        // Single request from requester 0
        bytes[0] = 8'h5A; req_mask = 4'b0001;
        cycle();
        check("single_no_early_xmit", bus.xmitH, 0);
        cycle();
        check("single_xmitH", bus.xmitH, 1);
        check("single_grant", bus.grantH, 4'b0001);
        check("single_data", bus.xmit_dataH, 8'h5A);
        run_until_done(20, "single");
        check("single_doneH", last_done, 4'b0001);

        // Transmitter busy holds off arbitration
        force_low = 1; bytes[2] = 8'hC3; req_mask = 4'b0100;
        start_n = n_launch;
        repeat (6) cycle();
        check("busy_no_launch", n_launch - start_n, 0);
        force_low = 0;
        cycle();
        check("busy_arb_cycle_xmitH", bus.xmitH, 0);
        cycle();
        check("busy_xmitH", bus.xmitH, 1);
        check("busy_grant", bus.grantH, 4'b0100);
        check("busy_data", bus.xmit_dataH, 8'hC3);
        run_until_done(20, "busy");

        // Request arriving during another requester's frame waits for doneH
        len_min = 6; len_max = 6;
        bytes[0] = 8'h11; req_mask = 4'b0001;
        run_until_launch(10, "late0");
        cycle(); cycle();
        bytes[1] = 8'h22; req_mask[1] = 1'b1;
        start_n = n_launch;
        run_until_done(20, "late0");
        check("late_first_done", last_done, 4'b0001);
        check("late_no_early_grant", n_launch - start_n, 0);
        cycle();
        cycle();
        check("late_xmitH", bus.xmitH, 1);
        check("late_grant", bus.grantH, 4'b0010);
        check("late_data", bus.xmit_dataH, 8'h22);
        run_until_done(20, "late1");

        // Round-robin fairness from reset with all requesters active
        rst_req = 1; cycle(); rst_req = 0;
        len_min = 2; len_max = 5; auto_refill = 1;
        for (int i = 0; i < NR; i++) bytes[i] = 8'($urandom);
        req_mask = 4'b1111;
        grant_order.delete();
        for (int k = 0; k < 5; k++) run_until_launch(30, "rr");
        auto_refill = 0;
        check("rr_count", grant_order.size() >= 5, 1);
        for (int k = 0; k < 5 && k < grant_order.size(); k++)
            check($sformatf("rr_order%0d", k), grant_order[k], k % NR);
        drain("rr");

        // Reset in the middle of a frame
        len_min = 8; len_max = 8;
        bytes[0] = 8'hA5; req_mask = 4'b0001;
        run_until_launch(10, "rstmid");
        cycle(); cycle();
        rst_req = 1; cycle(); rst_req = 0;
        cycle();
        check_all_zero("rstmid");
        bytes[0] = 8'h3C; bytes[3] = 8'h77; req_mask = 4'b1001;
        start_n = n_done;
        run_until_launch(40, "rstmid_next");
        check("rstmid_no_done", n_done - start_n, 0);
        check("rstmid_grant_ptr0", last_grant, 4'b0001);
        check("rstmid_data", last_data, 8'h3C);
        drain("rstmid");

`ifdef UART_XMIT_ARB_TIMEOUT_EN
        // Transmitter stuck low in FRAME
        len_min = 3; len_max = 3;
        req_mask = 4'b0010; bytes[1] = 8'h66;
        run_until_launch(10, "to");
        cycle(); cycle();
        force_low = 1;
        start_n = n_done;
        repeat (20) cycle();
        check("to_flag", bus.timeoutH, 1);
        check("to_state_arb", bus.busyH, 0);
        check("to_no_done", n_done - start_n, 0);
        force_low = 0;
        repeat (2) cycle();
`endif

        // Randomized traffic with random frame lengths and idle glitches
        len_min = 1; len_max = 6; rand_req = 1;
        for (int k = 0; k < 400; k++) begin
            force_low = ($urandom_range(7) == 0);
            cycle();
        end
        force_low = 0; rand_req = 0;
        drain("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
